// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the simple RV32 in-order pipeline. Owns the
// program counter, drives the instruction-memory address and computes the PC
// for the next enabled edge: sequential pc+4, or a redirect from the execute
// stage branch unit. The redirect has priority over the pipeline stall so a
// taken branch is never dropped.
//
// Optional feature macro: FETCH_MISALIGN_EN
//   defined   - adds the `misaligned` output and forces redirect targets to
//               word alignment ({branch_addr[31:2], 2'b00}).
//   undefined - no `misaligned` port; branch_addr is loaded verbatim.
//
// Parameters:
//   RESET_PC      PC value loaded while rst is high.
//
// Ports:
//   clk           in   1   rising-edge clock
//   rst           in   1   asynchronous, active-high reset
//   stall         in   1   pipeline stall; holds pc when no redirect
//   branch_taken  in   1   redirect request for the current cycle
//   branch_addr   in   32  redirect target
//   pc            out  32  registered PC of the instruction being fetched
//   inst_addr     out  32  instruction memory address (copy of pc)
//   next_pc       out  32  value pc takes at the next enabled edge
//   misaligned    out  1   (FETCH_MISALIGN_EN only) redirect target not
//                          word-aligned
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic [31:0] pc,
    output logic [31:0] inst_addr,
`ifdef FETCH_MISALIGN_EN
    output logic        misaligned,
`endif
    output logic [31:0] next_pc
);

    logic [31:0] pc_p0;
    logic [31:0] target;
    logic [31:0] seq_pc;
    logic        pc_en;

    // Redirect target formation; alignment only applies with the macro.
    function automatic logic [31:0] redirect_target(input logic [31:0] addr);
`ifdef FETCH_MISALIGN_EN
        return {addr[31:2], 2'b00};
`else
        return addr;
`endif
    endfunction

    assign target = redirect_target(branch_addr);
    // Modulo-2^32 increment: 32'hFFFF_FFFC wraps to 0 by truncation.
    assign seq_pc = pc_p0 + 32'd4;

    always_comb begin
        next_pc = seq_pc;
        if (branch_taken) begin
            next_pc = target;
        end
    end

    // Branch overrides stall, so the register is enabled whenever a redirect
    // is requested even if the rest of the pipeline is frozen.
    assign pc_en = branch_taken | ~stall;

`ifdef FETCH_MISALIGN_EN
    assign misaligned = branch_taken & (branch_addr[1:0] != 2'b00);
`endif

    // ---- PC register (fetch stage boundary) ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_p0 <= RESET_PC;
        end else if (pc_en) begin
            pc_p0 <= next_pc;
        end
    end

    assign pc        = pc_p0;
    assign inst_addr = pc_p0;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] pc;
    logic [31:0] inst_addr;
    logic [31:0] next_pc;
`ifdef FETCH_MISALIGN_EN
    logic        misaligned;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: the PC the fetch stage should hold right now.
    logic [31:0] m_pc;

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .pc           (pc),
        .inst_addr    (inst_addr),
`ifdef FETCH_MISALIGN_EN
        .misaligned   (misaligned),
`endif
        .next_pc      (next_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Where a taken branch sends the PC, from the address rules alone.
    function automatic logic [31:0] model_target(input logic [31:0] a);
`ifdef FETCH_MISALIGN_EN
        return a - (a % 32'd4);
`else
        return a;
`endif
    endfunction

    // One cycle: drive at the falling edge, check combinational outputs,
    // advance through the rising edge, check the registered PC.
    task automatic step(input logic r, input logic s, input logic b, input logic [31:0] a);
        logic [31:0] exp_next;
        rst          = r;
        stall        = s;
        branch_taken = b;
        branch_addr  = a;
        if (r) m_pc = RESET_PC;
        #1;
        check("pc_before_edge", pc, m_pc);
        exp_next = b ? model_target(a) : m_pc + 32'd4;
        check("next_pc", next_pc, exp_next);
`ifdef FETCH_MISALIGN_EN
        check("misaligned", {31'd0, misaligned}, {31'd0, (b && (a % 32'd4) != 0)});
`endif
        @(posedge clk);
        #1;
        if (r)       m_pc = RESET_PC;
        else if (b)  m_pc = model_target(a);
        else if (!s) m_pc = m_pc + 32'd4;
        check("pc", pc, m_pc);
        check("inst_addr", inst_addr, m_pc);
        @(negedge clk);
    endtask

    initial begin
        rst          = 1'b1;
        stall        = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'd0;
        m_pc         = RESET_PC;
        @(negedge clk);

        // Reset held for 10 cycles
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 32'd0);
        check("reset_pc", pc, 32'h0);
        check("reset_next_pc", next_pc, 32'h4);
        // Branch during reset shows its target on next_pc but pc stays put
        step(1'b1, 1'b0, 1'b1, 32'h0000_1234);

        // Sequential fetch
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 32'd0);
        check("seq_end", pc, 32'h14);

        // Stall
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'd0);
        check("stall_hold", pc, 32'h14);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check("stall_resume", pc, 32'h18);

        // Branch
        step(1'b0, 1'b0, 1'b1, 32'h1000);
        check("branch_pc", pc, 32'h1000);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check("branch_seq", pc, 32'h1008);

        // Branch with stall
        step(1'b0, 1'b1, 1'b1, 32'h2000);
        check("branch_stall", pc, 32'h2000);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check("branch_stall_seq", pc, 32'h2004);

        // Held branch keeps reloading the target
        step(1'b0, 1'b0, 1'b1, 32'h3000);
        step(1'b0, 1'b0, 1'b1, 32'h3000);
        check("branch_held", pc, 32'h3000);

        // Wrap
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check("wrap", pc, 32'h0);

        // Misaligned target
        step(1'b0, 1'b0, 1'b1, 32'h1002);
`ifdef FETCH_MISALIGN_EN
        check("misalign_pc", pc, 32'h1000);
`else
        check("misalign_pc", pc, 32'h1002);
`endif

        // Reach 0x40 then assert reset mid-cycle with stall and branch high
        step(1'b0, 1'b0, 1'b1, 32'h38);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check("pre_reset_pc", pc, 32'h40);
        rst          = 1'b1;
        stall        = 1'b1;
        branch_taken = 1'b1;
        branch_addr  = 32'h5000;
        #1;
        check("async_reset_pc", pc, 32'h0);
        check("async_reset_inst_addr", inst_addr, 32'h0);
        m_pc = RESET_PC;
        @(posedge clk);
        #1;
        check("reset_over_branch", pc, 32'h0);
        @(negedge clk);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check("reset_release", pc, 32'h4);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            logic        r, s, b;
            logic [31:0] a;
            r = ($urandom_range(0, 49) == 0);
            s = ($urandom_range(0, 9) < 3);
            b = ($urandom_range(0, 9) < 2);
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFF0 | (a & 32'hF);
            step(r, s, b, a);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
